mem_port_arbiter: RTL

Parametrised N-port front-end for the memory system. It arbitrates NUM_PORTS CPU memory request channels (round-robin) onto the single request bus of the DDR controller. Read data returns in order and is routed back to the originating port through an in-order ID FIFO. It is the multi-master successor to the single-CPU memory_system bus attachment.

---
 rtl/mem_port_arbiter_if.sv | 37 +++
 rtl/mem_port_arbiter.sv | 136 +++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Request/response channels of mem_port_arbiter: NUM_PORTS CPU channels plus the downstream memory bus.
// slave is the arbiter's view; master is the requesters' and memory model's view.
interface mem_port_arbiter_if #(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
);
  logic [NUM_PORTS-1:0]            cpu_mem_valid;
  logic [NUM_PORTS-1:0]            cpu_mem_write;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] cpu_mem_addr;
  logic [NUM_PORTS*DATA_WIDTH-1:0] cpu_mem_wdata;
  logic [NUM_PORTS-1:0]            cpu_mem_ready;
  logic [DATA_WIDTH-1:0]           cpu_mem_rdata;
  logic [NUM_PORTS-1:0]            cpu_mem_rvalid;

  logic                            mem_valid;
  logic                            mem_write;
  logic [ADDR_WIDTH-1:0]           mem_addr;
  logic [DATA_WIDTH-1:0]           mem_wdata;
  logic                            mem_ready;
  logic [DATA_WIDTH-1:0]           mem_rdata;
  logic                            mem_rvalid;

  modport slave (
    input  cpu_mem_valid, cpu_mem_write, cpu_mem_addr, cpu_mem_wdata,
    output cpu_mem_ready, cpu_mem_rdata, cpu_mem_rvalid,
    output mem_valid, mem_write, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata, mem_rvalid
  );

  modport master (
    output cpu_mem_valid, cpu_mem_write, cpu_mem_addr, cpu_mem_wdata,
    input  cpu_mem_ready, cpu_mem_rdata, cpu_mem_rvalid,
    input  mem_valid, mem_write, mem_addr, mem_wdata,
    output mem_ready, mem_rdata, mem_rvalid
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter of NUM_PORTS CPU request channels onto one memory bus; in-order read
// responses are steered back to their requester through an ID FIFO.
module mem_port_arbiter #(
  parameter int NUM_PORTS       = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 64,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                               sys_clk,
  input  logic                               sys_rst_n,
  mem_port_arbiter_if.slave                  bus,
  output logic [$clog2(MAX_OUTSTANDING):0]   rd_outstanding,
  output logic                               err_unexpected_rsp
);
  localparam int PTR_W = $clog2(NUM_PORTS);
  localparam int FA_W  = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = FA_W + 1;

  localparam logic [0:0] ST_ARB   = 1'b0;
  localparam logic [0:0] ST_ISSUE = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0] grant_q, grant_d;
  logic [FA_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [FA_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;
  logic [PTR_W-1:0] id_fifo_q [MAX_OUTSTANDING];

  logic [ADDR_WIDTH-1:0] port_addr  [NUM_PORTS];
  logic [DATA_WIDTH-1:0] port_wdata [NUM_PORTS];
  logic [NUM_PORTS-1:0]  eligible;
  logic [PTR_W-1:0]      pick, cand, head_id;
  logic                  found, fifo_full, fifo_empty;
  logic                  issuing, grant_write, accept, push, pop;

  assign fifo_full   = (count_q == CNT_W'(MAX_OUTSTANDING));
  assign fifo_empty  = (count_q == '0);
  // Writes bypass the full check: only reads need an ID slot.
  assign eligible    = bus.cpu_mem_valid & (bus.cpu_mem_write | {NUM_PORTS{~fifo_full}});
  assign issuing     = (state_q == ST_ISSUE);
  assign grant_write = bus.cpu_mem_write[grant_q];
  assign accept      = issuing && bus.mem_ready;
  assign push        = accept && !grant_write;
  assign pop         = bus.mem_rvalid && !fifo_empty;
  assign head_id     = id_fifo_q[rd_ptr_q];

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      port_addr[p]  = bus.cpu_mem_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
      port_wdata[p] = bus.cpu_mem_wdata[p*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // First eligible port at or after rr_ptr, wrapping.
  always_comb begin
    // NOTE: every output gets a default up front so no path leaves it unassigned (no latch).
    pick  = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = PTR_W'((int'(rr_ptr_q) + k) % NUM_PORTS);
      if (!found && eligible[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ST_ARB: begin
        if (found) begin
          grant_d = pick;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (accept) begin
          rr_ptr_d = PTR_W'((int'(grant_q) + 1) % NUM_PORTS);
          state_d  = ST_ARB;
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + FA_W'(push);
    rd_ptr_d = rd_ptr_q + FA_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    err_d    = err_q | (bus.mem_rvalid & fifo_empty);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= ST_ARB;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every flop samples pre-edge values.
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  // NOTE: ID storage is not reset; the pointers and count alone decide which entries are live.
  always_ff @(posedge sys_clk) begin
    if (push) id_fifo_q[wr_ptr_q] <= grant_q;
  end

  // Payload is forced to zero outside ISSUE so the bus is quiet in reset and while arbitrating.
  assign bus.mem_valid      = issuing;
  assign bus.mem_write      = issuing & grant_write;
  assign bus.mem_addr       = issuing ? port_addr[grant_q]  : '0;
  assign bus.mem_wdata      = issuing ? port_wdata[grant_q] : '0;
  assign bus.cpu_mem_ready  = accept ? (NUM_PORTS'(1) << grant_q) : '0;
  assign bus.cpu_mem_rvalid = pop ? (NUM_PORTS'(1) << head_id) : '0;
  assign bus.cpu_mem_rdata  = pop ? bus.mem_rdata : '0;

  assign rd_outstanding     = count_q;
  assign err_unexpected_rsp = err_q;
endmodule
